risc_ctrl_seq: RTL and testbench

//  Parametrised successor to the RISC control unit. It is the 8-phase instruction sequencer

---
 rtl/risc_pkg.sv | 30 +++
 rtl/risc_ctrl_decode.sv | 78 +++++++
 rtl/risc_ctrl_seq.sv | 97 +++++++++
 tb/tb_risc_ctrl_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC control sequencer: opcode values, the
// eight sequencer phases, and the ALU-opcode classifier.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational control decode: phase + opcode + zero flag -> datapath
// controls. Opcodes above 7 decode as no-ops; halt forces every control low.
module risc_ctrl_decode
  import risc_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  logic [2:0]       phase,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             halt,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             op_halt,
  output logic             op_illegal
);

  logic       hi_bits;
  logic [2:0] op3;
  logic       alu, jmp, sto, skz;

  if (OPC_W > 3) begin : g_wide
    assign hi_bits = |opcode[OPC_W-1:3];
  end else begin : g_narrow
    assign hi_bits = 1'b0;
  end

  assign op3        = opcode[2:0];
  assign op_illegal = hi_bits;
  assign op_halt    = !hi_bits && (op3 == HLT);
  assign alu        = !hi_bits && is_aluop(op3);
  assign jmp        = !hi_bits && (op3 == JMP);
  assign sto        = !hi_bits && (op3 == STO);
  assign skz        = !hi_bits && (op3 == SKZ);

  // Per-phase control word; everything defaults low and stays low while halted.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    if (!halt) begin
      case (phase)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    inc_pc = 1'b1;
        OP_FETCH:   rd = alu;
        ALU_OP: begin
          rd     = alu;
          inc_pc = skz & zero;
          ld_pc  = jmp;
        end
        STORE: begin
          rd     = alu;
          ld_ac  = alu;
          inc_pc = jmp;
          ld_pc  = jmp;
          data_e = sto;
          wr     = sto;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/risc_ctrl_seq.sv
// 8-phase RISC instruction sequencer with memory wait-state stalls,
// halt/resume and single-step. Holds the phase register and the sticky
// halt/illegal flags; control decode lives in risc_ctrl_decode.
module risc_ctrl_seq
  import risc_pkg::*;
#(
  parameter int OPC_W    = 3,
  parameter int STALL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  input  logic             step_mode,
  input  logic             step,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic             illegal,
  output logic [2:0]       phase
);

  phase_e     phase_q, phase_d;
  logic       halt_q, halt_d;
  logic       illegal_q, illegal_d;
  logic       op_halt, op_illegal;
  logic       stall, step_hold;
  logic [2:0] phase_inc;

  risc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .phase      (phase_q),
    .opcode     (opcode),
    .zero       (zero),
    .halt       (halt_q),
    .sel        (sel),
    .rd         (rd),
    .ld_ir      (ld_ir),
    .inc_pc     (inc_pc),
    .ld_pc      (ld_pc),
    .ld_ac      (ld_ac),
    .data_e     (data_e),
    .wr         (wr),
    .op_halt    (op_halt),
    .op_illegal (op_illegal)
  );

  // A fetch phase waits for memory only when it is actually reading.
  assign stall = (STALL_EN != 0) && !mem_ready && rd &&
                 ((phase_q == INST_FETCH) || (phase_q == OP_FETCH));
  assign step_hold = step_mode && (phase_q == INST_ADDR) && !step;
  assign phase_inc = phase_q + 3'd1;

  // Next-state: resume leaves halt into OP_FETCH (PC already bumped in OP_ADDR);
  // HLT or an out-of-range opcode freezes the sequencer at OP_ADDR.
  always_comb begin
    phase_d   = phase_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    if (halt_q) begin
      if (resume) begin
        halt_d  = 1'b0;
        phase_d = OP_FETCH;
      end
    end else if ((phase_q == OP_ADDR) && (op_halt || op_illegal)) begin
      halt_d    = 1'b1;
      illegal_d = illegal_q | op_illegal;
    end else if (!stall && !step_hold) begin
      phase_d = phase_e'(phase_inc);
    end
  end

  // State register; reset is asynchronous so controls drop without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= INST_ADDR;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  assign halt    = halt_q;
  assign illegal = illegal_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Self-checking bench for risc_ctrl_seq (OPC_W=4 so illegal opcodes are reachable).
module tb_risc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0, mem_ready = 1'b1, resume = 1'b0;
  logic       step_mode = 1'b0, step = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr;
  logic       halt, illegal;
  logic [2:0] phase;
  logic [7:0] ctl;

  int tests = 0;
  int fails = 0;

  risc_ctrl_seq #(.OPC_W(4), .STALL_EN(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_mode(step_mode), .step(step),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr),
    .halt(halt), .illegal(illegal), .phase(phase)
  );

  assign ctl = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; resume = 1'b0; step = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Reference control word {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr} from the decode table.
  function automatic logic [7:0] exp_ctrl(input int ph, input int op, input logic z, input logic h);
    logic alu, jmp, sto, skz;
    alu = (op >= 2) && (op <= 5);
    jmp = (op == 7);
    sto = (op == 6);
    skz = (op == 1);
    if (h) return 8'h00;
    case (ph)
      0:       return 8'b1000_0000;
      1:       return 8'b1100_0000;
      2, 3:    return 8'b1110_0000;
      4:       return 8'b0001_0000;
      5:       return {1'b0, alu, 6'b0};
      6:       return {1'b0, alu, 1'b0, skz & z, jmp, 3'b0};
      default: return {1'b0, alu, 1'b0, jmp, jmp, alu, sto, sto};
    endcase
  endfunction

  task automatic test_reset();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase: got %0d want 0", phase); end
    tests++;
    if (ctl !== 8'h80) begin fails++; $display("FAIL reset_ctl: got %b want 10000000", ctl); end
    tests++;
    if (halt !== 1'b0 || illegal !== 1'b0) begin
      fails++; $display("FAIL reset_flags: halt=%b illegal=%b want 0 0", halt, illegal);
    end
  endtask

  task automatic test_halt_resume();
    opcode = 4'd0; mem_ready = 1'b1; step_mode = 1'b0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (halt !== 1'b0 || phase !== 3'(k)) begin
        fails++; $display("FAIL hlt_run edge %0d: halt=%b phase=%0d want 0 %0d", k, halt, phase, k);
      end
    end
    tick();
    tests++;
    if (halt !== 1'b1 || phase !== 3'd4 || ctl !== 8'h00) begin
      fails++; $display("FAIL hlt_set: halt=%b phase=%0d ctl=%b want 1 4 00000000", halt, phase, ctl);
    end
    tick(); tick();
    tests++;
    if (halt !== 1'b1 || phase !== 3'd4) begin
      fails++; $display("FAIL hlt_hold: halt=%b phase=%0d want 1 4", halt, phase);
    end
    resume = 1'b1; step = 1'b1;
    tick();
    resume = 1'b0; step = 1'b0;
    tests++;
    if (halt !== 1'b0 || phase !== 3'd5) begin
      fails++; $display("FAIL hlt_resume: halt=%b phase=%0d want 0 5", halt, phase);
    end
  endtask

  task automatic test_jmp();
    opcode = 4'd7; mem_ready = 1'b1;
    do_reset();
    repeat (6) tick();
    tests++;
    if (phase !== 3'd6 || ld_pc !== 1'b1 || inc_pc !== 1'b0) begin
      fails++; $display("FAIL jmp_alu: phase=%0d ld_pc=%b inc_pc=%b want 6 1 0", phase, ld_pc, inc_pc);
    end
    tick();
    tests++;
    if (phase !== 3'd7 || ld_pc !== 1'b1 || inc_pc !== 1'b1) begin
      fails++; $display("FAIL jmp_store: phase=%0d ld_pc=%b inc_pc=%b want 7 1 1", phase, ld_pc, inc_pc);
    end
    tick();
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL jmp_wrap: phase=%0d want 0", phase); end
  endtask

  task automatic test_skz();
    opcode = 4'd1; zero = 1'b1; mem_ready = 1'b1;
    do_reset();
    repeat (6) tick();
    tests++;
    if (inc_pc !== 1'b1) begin fails++; $display("FAIL skz_zero1: inc_pc=%b want 1", inc_pc); end
    zero = 1'b0;
    #1;
    tests++;
    if (inc_pc !== 1'b0) begin fails++; $display("FAIL skz_zero0: inc_pc=%b want 0", inc_pc); end
    tick();
    tests++;
    if (phase !== 3'd7 || ld_ac !== 1'b0) begin
      fails++; $display("FAIL skz_store: phase=%0d ld_ac=%b want 7 0", phase, ld_ac);
    end
  endtask

  task automatic test_stall();
    int edges;
    bit done;
    opcode = 4'd6; mem_ready = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (phase !== 3'd1 || rd !== 1'b1 || sel !== 1'b1) begin
        fails++; $display("FAIL stall_hold %0d: phase=%0d rd=%b sel=%b want 1 1 1", k, phase, rd, sel);
      end
    end
    mem_ready = 1'b1;
    edges = 4;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      edges++;
      tests++;
      if (wr !== (phase == 3'd7)) begin
        fails++; $display("FAIL stall_wr: phase=%0d wr=%b", phase, wr);
      end
      if (phase == 3'd0) done = 1'b1;
    end
    tests++;
    if (edges != 11) begin fails++; $display("FAIL stall_len: got %0d edges want 11", edges); end
  endtask

  task automatic test_step();
    opcode = 4'd2; mem_ready = 1'b1; step_mode = 1'b1;
    do_reset();
    repeat (20) tick();
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL step_idle: phase=%0d want 0", phase); end
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tests++;
      if (phase !== 3'(k)) begin fails++; $display("FAIL step_run: phase=%0d want %0d", phase, k); end
      tick();
    end
    repeat (5) tick();
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL step_rehold: phase=%0d want 0", phase); end
    step_mode = 1'b0;
  endtask

  task automatic test_illegal_reset();
    opcode = 4'hA; mem_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    tests++;
    if (halt !== 1'b1 || illegal !== 1'b1 || phase !== 3'd4 || ctl !== 8'h00) begin
      fails++; $display("FAIL ill_set: halt=%b illegal=%b phase=%0d ctl=%b want 1 1 4 0", halt, illegal, phase, ctl);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tests++;
    if (halt !== 1'b0 || illegal !== 1'b1 || phase !== 3'd5) begin
      fails++; $display("FAIL ill_resume: halt=%b illegal=%b phase=%0d want 0 1 5", halt, illegal, phase);
    end
    opcode = 4'd6;
    tick(); tick();
    tests++;
    if (phase !== 3'd7 || wr !== 1'b1 || data_e !== 1'b1) begin
      fails++; $display("FAIL sto_store: phase=%0d wr=%b data_e=%b want 7 1 1", phase, wr, data_e);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (wr !== 1'b0 || data_e !== 1'b0 || phase !== 3'd0 || sel !== 1'b1 || illegal !== 1'b0 || halt !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: wr=%b data_e=%b phase=%0d sel=%b illegal=%b halt=%b want 0 0 0 1 0 0",
               wr, data_e, phase, sel, illegal, halt);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    int  mph;
    bit  mh, mi;
    int  op;
    logic [7:0] ec;
    step_mode = 1'b0;
    do_reset();
    mph = 0; mh = 1'b0; mi = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      op        = ($urandom % 8 == 0) ? int'(8 + $urandom % 8) : int'($urandom % 8);
      opcode    = 4'(op);
      zero      = 1'($urandom % 2);
      mem_ready = ($urandom % 3 != 0);
      resume    = ($urandom % 6 == 0) || (mh && ($urandom % 3 == 0));
      step      = ($urandom % 3 == 0);
      if (c % 150 == 0) step_mode = 1'($urandom % 2);
      #1;
      ec = exp_ctrl(mph, op, zero, mh);
      tests++;
      if (phase !== 3'(mph) || halt !== mh || illegal !== mi || ctl !== ec) begin
        fails++;
        $display("FAIL random cyc %0d op %0d: phase=%0d halt=%b illegal=%b ctl=%b want %0d %b %b %b",
                 c, op, phase, halt, illegal, ctl, mph, mh, mi, ec);
      end
      if (mh) begin
        if (resume) begin mh = 1'b0; mph = 5; end
      end else if (mph == 4 && (op == 0 || op > 7)) begin
        mh = 1'b1;
        if (op > 7) mi = 1'b1;
      end else if (!mem_ready && (mph == 1 || (mph == 5 && op >= 2 && op <= 5))) begin
        mph = mph;
      end else if (step_mode && mph == 0 && !step) begin
        mph = mph;
      end else begin
        mph = (mph + 1) % 8;
      end
      @(posedge clk);
      #1;
    end
    resume = 1'b0; step = 1'b0; step_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_halt_resume();
    test_jmp();
    test_skz();
    test_stall();
    test_step();
    test_illegal_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
